board_renderer: RTL and testbench
=================================

Name: board_renderer

Overview:
- Downstream of the grid datapath and cursor logic in the tic-tac-toe game.
- On request, it snapshots the 9-cell board state and the cursor position.
- It then scans the 3x3 board region one pixel per clock and drives pixel writes (x, y, colour, plot) to the VGA adapter, which runs at 160x120 with 3-bit colour.
- It provides a start/busy/done handshake and queues one pending redraw.

Parameters:
- CELL, 32, cell edge length in pixels (min 12); board is 3*CELL square.
- X0, 32, board left edge x coordinate; X0+3*CELL <= 160.
- Y0, 12, board top edge y coordinate; Y0+3*CELL <= 120.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  redraw request, sampled each cycle.
- board  input  18  cell c occupies board[2c+1:2c]: 00 empty, 01 player one (O), 10 player two (X), 11 treated as empty.
- cursor  input  4  selected cell 0..8; values 9..15 mean no highlight.
- x  output  8  pixel x coordinate.
- y  output  7  pixel y coordinate.
- colour  output  3  pixel colour {R,G,B}.
- plot  output  1  pixel write strobe.
- busy  output  1  high while drawing.
- done  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (takes priority over everything, including mid-frame):
  - Next edge: state IDLE, pending=0.
  - x=0, y=0, colour=0, plot=0, busy=0, done=0.
  - No done pulse for an aborted frame.
- States: IDLE, DRAW, FIN.
- IDLE:
  - If start=1 at an edge, then in the same edge: snapshot board/cursor, set pixel counters px=0, py=0, go to DRAW.
- DRAW:
  - busy=1 throughout.
  - Each cycle the registered outputs present pixel (X0+px, Y0+py) with plot=1.
  - px increments 0..3*CELL-1 and wraps to 0 with py+1 (row-major order).
  - After the pixel px=py=3*CELL-1 is presented, go to FIN.
  - Exactly (3*CELL)^2 plot cycles per frame, contiguous, no gaps.
- FIN: one cycle, done=1, plot=0, busy=0.
  - If pending=1 (or start=1 during FIN): clear pending, take a fresh snapshot, enter DRAW next cycle.
  - Otherwise return to IDLE.
- Latency: start high at edge N → busy=1 and first plot=1 visible after edge N; first pixel (X0, Y0).
- start=1 in DRAW sets pending. Multiple requests collapse into one.
- The snapshot is stable for the whole frame; board/cursor changes mid-frame do not affect it.
- Pixel colour, with local coords lx=px mod CELL, ly=py mod CELL and cell c=(py/CELL)*3+(px/CELL); first match wins:
  - Border (lx==0, ly==0, lx==CELL-1 or ly==CELL-1): 110 if c==cursor snapshot, else 111.
  - Cell O and inset ring (lx,ly in [4,CELL-5] and lx or ly equal to 4 or CELL-5): 100.
  - Cell X, inside the inset, and (lx==ly or lx+ly==CELL-1): 001.
  - Otherwise: 000.
- Counters and division must not require a divider: keep separate cell-column/cell-row counters and local counters.

Test Plan:
- Reset, board=0, cursor=0, pulse start one cycle:
  - busy=1 next cycle; exactly 9216 plot cycles.
  - First pixel (32,12) colour 110; (48,28) colour 000; (64,12) colour 111.
  - Last pixel (127,107); done pulses once, the cycle after the last plot; then busy=0.
- board[9:8]=10 (X at cell 4), cursor=9:
  - (74,54)=001, (74,65)=001, (75,54)=000.
  - (64,44)=111; no 110 anywhere in the frame.
- board[17:16]=01 (O at cell 8):
  - (100,86)=100, (100,80)=100, (110,90)=000.
  - (96,76)=111 with cursor=0.
- Start again mid-frame at plot 1000 with board changed to all 10s:
  - First frame colours still match the old snapshot.
  - done pulse, then busy re-asserts the next cycle; a second full 9216-plot frame shows X in every cell.
- Assert reset at plot 5000:
  - Next cycle plot=0, busy=0, x=y=colour=0; done never pulses.
  - A start afterwards begins cleanly at (32,12).
- board=2'b11 in cell 0 → cell 0 is rendered as empty (interior pixels 000).

Source files
------------

// File: rtl/board_renderer.sv
// Tic-tac-toe board scanner: snapshots board/cursor on request and emits one
// pixel write per clock over the 3x3 board region, with one queued redraw.
module board_renderer #(
    parameter int CELL = 32,
    parameter int X0   = 32,
    parameter int Y0   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] board,
    input  logic [3:0]  cursor,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);
    localparam int LW = $clog2(CELL);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [LW-1:0] L_ONE = LW'(1);
    localparam logic [LW-1:0] L_MAX = LW'(CELL - 1);
    localparam logic [LW-1:0] L_IN0 = LW'(4);
    localparam logic [LW-1:0] L_IN1 = LW'(CELL - 5);

    logic [1:0]    state_q, state_d;
    logic          pending_q, pending_d;
    logic [17:0]   snap_board_q, snap_board_d;
    logic [3:0]    snap_cur_q, snap_cur_d;
    logic [1:0]    cx_q, cx_d, cy_q, cy_d;
    logic [LW-1:0] lx_q, lx_d, ly_q, ly_d;
    logic [7:0]    px_q, px_d;
    logic [6:0]    py_q, py_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic          load, present, last;

    assign last = (cx_q == 2'd2) && (lx_q == L_MAX) && (cy_q == 2'd2) && (ly_q == L_MAX);

    // Counters hold the pixel currently on the outputs; the pixel logic below
    // renders the *next* counter values so the outputs stay fully registered.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        snap_board_d = snap_board_q;
        snap_cur_d   = snap_cur_q;
        cx_d = cx_q; cy_d = cy_q; lx_d = lx_q; ly_d = ly_q;
        px_d = px_q; py_d = py_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        present = 1'b0;
        case (state_q)
            S_IDLE: if (start) load = 1'b1;
            S_DRAW: begin
                pending_d = pending_q | start;
                if (last) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    present = 1'b1;
                    if (lx_q == L_MAX) begin
                        lx_d = '0;
                        if (cx_q == 2'd2) begin
                            cx_d = 2'd0;
                            px_d = 8'd0;
                            py_d = py_q + 7'd1;
                            if (ly_q == L_MAX) begin
                                ly_d = '0;
                                cy_d = cy_q + 2'd1;
                            end else begin
                                ly_d = ly_q + L_ONE;
                            end
                        end else begin
                            cx_d = cx_q + 2'd1;
                            px_d = px_q + 8'd1;
                        end
                    end else begin
                        lx_d = lx_q + L_ONE;
                        px_d = px_q + 8'd1;
                    end
                end
            end
            S_FIN: begin
                if (pending_q || start) begin
                    load      = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            snap_board_d = board;
            snap_cur_d   = cursor;
            cx_d = 2'd0; cy_d = 2'd0; lx_d = '0; ly_d = '0;
            px_d = 8'd0; py_d = 7'd0;
            state_d = S_DRAW;
            present = 1'b1;
        end
        if (present) begin
            plot_d = 1'b1;
            busy_d = 1'b1;
        end
    end

    logic [3:0] cell_idx;
    logic [1:0] cell_val;
    logic       on_border, in_inset, on_ring, on_diag;

    always_comb begin
        cell_idx  = ({2'b00, cy_d} * 4'd3) + {2'b00, cx_d};
        cell_val  = snap_board_d[{cell_idx, 1'b0} +: 2];
        on_border = (lx_d == '0) || (ly_d == '0) || (lx_d == L_MAX) || (ly_d == L_MAX);
        in_inset  = (lx_d >= L_IN0) && (lx_d <= L_IN1) && (ly_d >= L_IN0) && (ly_d <= L_IN1);
        on_ring   = in_inset && ((lx_d == L_IN0) || (ly_d == L_IN0) ||
                                 (lx_d == L_IN1) || (ly_d == L_IN1));
        on_diag   = in_inset && ((lx_d == ly_d) ||
                                 (({1'b0, lx_d} + {1'b0, ly_d}) == (LW + 1)'(CELL - 1)));
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        if (present) begin
            x_d = 8'(X0) + px_d;
            y_d = 7'(Y0) + py_d;
            if (on_border)
                colour_d = (cell_idx == snap_cur_d) ? 3'b110 : 3'b111;
            else if (cell_val == 2'b01 && on_ring)
                colour_d = 3'b100;
            else if (cell_val == 2'b10 && on_diag)
                colour_d = 3'b001;
            else
                colour_d = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            snap_board_q <= '0;
            snap_cur_q   <= '0;
            cx_q <= '0; cy_q <= '0; lx_q <= '0; ly_q <= '0;
            px_q <= '0; py_q <= '0;
            x_q <= '0; y_q <= '0; colour_q <= '0;
            plot_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            snap_board_q <= snap_board_d;
            snap_cur_q   <= snap_cur_d;
            cx_q <= cx_d; cy_q <= cy_d; lx_q <= lx_d; ly_q <= ly_d;
            px_q <= px_d; py_q <= py_d;
            x_q <= x_d; y_q <= y_d; colour_q <= colour_d;
            plot_q <= plot_d; busy_q <= busy_d; done_q <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: frames are captured into an image and
// spot pixels compared against hand-computed colours.
module tb_board_renderer;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [17:0] board_i;
    logic [3:0]  cursor_i;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    board_renderer #(.CELL(32), .X0(32), .Y0(12)) dut (
        .clk(clk), .reset(reset), .start(start), .board(board_i), .cursor(cursor_i),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] b;
        logic [3:0]  c;
        int          px;
        int          py;
        int          col;
    } vec_t;

    vec_t       vecs[14];
    logic [2:0] img[0:9215];
    int tests = 0, fails = 0;
    int nplot, last_x, last_y;
    bit seen110;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pix(input int px, input int py);
        return int'(img[(py - 12) * 96 + (px - 32)]);
    endfunction

    // Pulse start at a negedge; the next negedge must show the first pixel.
    task automatic start_frame(input logic [17:0] b, input logic [3:0] c);
        board_i = b; cursor_i = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_busy", busy, 1);
        chk("first_plot", plot, 1);
        chk("first_x", x, 32);
        chk("first_y", y, 12);
    endtask

    // Records plotted pixels until done; optionally queues a redraw with a
    // new board once inject_at pixels have been seen.
    task automatic capture(input int inject_at, input logic [17:0] nb);
        int cyc = 0;
        bit injected = 0;
        nplot = 0; seen110 = 0;
        while (done !== 1'b1 && cyc < 12000) begin
            if (plot) begin
                if (x < 32 || x > 127 || y < 12 || y > 107) begin
                    chk("pixel_range", 0, 1);
                end else begin
                    img[(int'(y) - 12) * 96 + (int'(x) - 32)] = colour;
                end
                if (colour == 3'b110) seen110 = 1;
                last_x = x; last_y = y;
                nplot++;
            end
            if (start) start = 1'b0;
            if (inject_at > 0 && !injected && nplot == inject_at) begin
                board_i = nb; start = 1'b1; injected = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("done_plot", plot, 0);
        chk("done_busy", busy, 0);
        chk("plot_count", nplot, 9216);
        chk("last_x", last_x, 127);
        chk("last_y", last_y, 107);
    endtask

    task automatic run_frame(input logic [17:0] b, input logic [3:0] c);
        start_frame(b, c);
        capture(0, 18'h0);
        @(negedge clk);
        chk("after_busy", busy, 0);
        chk("after_done", done, 0);
    endtask

    initial begin
        bit          have;
        logic [17:0] fb;
        logic [3:0]  fc;
        int          n, cyc, dn, pl;

        vecs[0]  = '{18'h00000, 4'd0, 32, 12, 6};
        vecs[1]  = '{18'h00000, 4'd0, 48, 28, 0};
        vecs[2]  = '{18'h00000, 4'd0, 64, 12, 7};
        vecs[3]  = '{18'h00000, 4'd0, 127, 107, 7};
        vecs[4]  = '{18'h00200, 4'd9, 74, 54, 1};
        vecs[5]  = '{18'h00200, 4'd9, 74, 65, 1};
        vecs[6]  = '{18'h00200, 4'd9, 75, 54, 0};
        vecs[7]  = '{18'h00200, 4'd9, 64, 44, 7};
        vecs[8]  = '{18'h10000, 4'd0, 100, 86, 4};
        vecs[9]  = '{18'h10000, 4'd0, 100, 80, 4};
        vecs[10] = '{18'h10000, 4'd0, 110, 90, 0};
        vecs[11] = '{18'h10000, 4'd0, 96, 76, 7};
        vecs[12] = '{18'h00003, 4'd9, 36, 20, 0};
        vecs[13] = '{18'h00003, 4'd9, 42, 22, 0};

        reset = 1'b1; start = 1'b0; board_i = '0; cursor_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_xyc", {x, y, colour}, 0);
        reset = 1'b0;
        @(negedge clk);

        have = 0; fb = '0; fc = '0;
        for (int i = 0; i < 14; i++) begin
            if (!have || vecs[i].b != fb || vecs[i].c != fc) begin
                run_frame(vecs[i].b, vecs[i].c);
                if (vecs[i].b == 18'h00200) chk("no_highlight", int'(seen110), 0);
                have = 1; fb = vecs[i].b; fc = vecs[i].c;
            end
            chk($sformatf("vec%0d_(%0d,%0d)", i, vecs[i].px, vecs[i].py),
                pix(vecs[i].px, vecs[i].py), vecs[i].col);
        end

        // Redraw request mid-frame with a new board.
        start_frame(18'h10000, 4'd0);
        capture(1000, 18'h2AAAA);
        chk("old_snap_o", pix(100, 86), 4);
        chk("old_snap_c0", pix(52, 32), 0);
        @(negedge clk);
        chk("requeue_busy", busy, 1);
        chk("requeue_plot", plot, 1);
        chk("requeue_xy", {x, y}, {8'd32, 7'd12});
        capture(0, 18'h0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                chk($sformatf("x_cell%0d", r * 3 + c), pix(42 + c * 32, 22 + r * 32), 1);
        @(negedge clk);
        chk("requeue_idle", busy, 0);

        // Reset mid-frame.
        start_frame(18'h00000, 4'd0);
        n = 1; cyc = 0;
        while (n < 5000 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (plot) n++;
        end
        chk("reach_5000", n, 5000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_xyc", {x, y, colour}, 0);
        dn = 0; pl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (plot) pl++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_no_plot", pl, 0);
        run_frame(18'h00000, 4'd0);
        chk("restart_corner", pix(32, 12), 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
